// File: rtl/mult_operand_sequencer.sv
// rtl/mult_operand_sequencer.sv - global phase counter and multiplier operand sequencer
// Runs a calibration phase that loads/clears operands, then streams ADC samples.
module mult_operand_sequencer #(
  parameter int DW       = 32,
  parameter int NCH      = 2,
  parameter int CW       = 5,
  parameter int STD_PH_A = 1,
  parameter int STD_PH_B = 7,
  parameter int CLR_PH   = 20,
  parameter int RUN_PH   = 23,
  parameter int RUN_LEN  = 16,
  parameter int SCW      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [NCH*DW-1:0]   std_i,
  input  logic [NCH*DW-1:0]   adc_effective,
  input  logic                adc_valid,
  output logic [CW-1:0]       count_global,
  output logic [NCH*DW-1:0]   mult_2,
  output logic                mult_valid,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0]  PH_A        = CW'(STD_PH_A);
  localparam logic [CW-1:0]  PH_B        = CW'(STD_PH_B);
  localparam logic [CW-1:0]  PH_CLR      = CW'(CLR_PH);
  localparam logic [CW-1:0]  PH_RUN      = CW'(RUN_PH);
  localparam logic [CW-1:0]  PH_FIRST    = CW'(1);
  localparam logic [SCW-1:0] LAST_SAMPLE = SCW'((RUN_LEN == 0) ? 0 : RUN_LEN - 1);

  generate
    if (!(0 < STD_PH_A && STD_PH_A < STD_PH_B && STD_PH_B < CLR_PH &&
          CLR_PH < RUN_PH && RUN_PH <= (2 ** CW) - 1)) begin : g_bad_phases
      $fatal(1, "mult_operand_sequencer: illegal phase parameters");
    end
    if (RUN_LEN < 0 || RUN_LEN >= (2 ** SCW)) begin : g_bad_run_len
      $fatal(1, "mult_operand_sequencer: RUN_LEN out of range");
    end
  endgenerate

  state_t         state;
  logic [SCW-1:0] sample_cnt;

  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count_global <= '0;
      mult_2       <= '0;
      mult_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_cnt   <= '0;
    end else begin
      mult_valid <= 1'b0;
      done       <= 1'b0;
      if (stop) begin
        state        <= IDLE;
        busy         <= 1'b0;
        count_global <= '0;
      end else begin
        case (state)
          IDLE: begin
            count_global <= '0;
            if (start) begin
              state        <= CAL;
              busy         <= 1'b1;
              count_global <= PH_FIRST;
              sample_cnt   <= '0;
            end
          end
          CAL: begin
            if (count_global == PH_A || count_global == PH_B) begin
              mult_2     <= std_i;
              mult_valid <= 1'b1;
            end else if (count_global == PH_CLR) begin
              mult_2     <= '0;
              mult_valid <= 1'b1;
            end
            // The counter parks on RUN_PH for the whole run phase
            if (count_global < PH_RUN) begin
              count_global <= count_global + 1'b1;
            end else begin
              state <= RUN;
            end
          end
          RUN: begin
            count_global <= PH_RUN;
            if (adc_valid) begin
              mult_2     <= adc_effective;
              mult_valid <= 1'b1;
              sample_cnt <= sample_cnt + 1'b1;
              if (RUN_LEN != 0 && sample_cnt == LAST_SAMPLE) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          DONE: begin
            state        <= IDLE;
            busy         <= 1'b0;
            count_global <= '0;
          end
          default: begin
            state        <= IDLE;
            busy         <= 1'b0;
            count_global <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// tb/tb_mult_operand_sequencer.sv - bench for mult_operand_sequencer
// Two instances (RUN_LEN=4 and RUN_LEN=0) share stimulus; a behavioural model predicts both.
module tb_mult_operand_sequencer;
  localparam int DW  = 32;
  localparam int NCH = 2;
  localparam int CW  = 5;
  localparam int SCW = 16;
  localparam int W   = NCH * DW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         adc_valid = 1'b0;
  logic [W-1:0] std_i = '0;
  logic [W-1:0] adc_effective = '0;

  logic [CW-1:0] count_global [2];
  logic [W-1:0]  mult_2 [2];
  logic          mult_valid [2];
  logic          busy [2];
  logic          done [2];
  logic [1:0]    state_o [2];

  int run_len [2] = '{4, 0};
  int passed = 0;
  int failed = 0;
  int total  = 0;
  int ncyc   = 0;

  typedef struct {
    int           st;
    int           cg;
    logic [W-1:0] m2;
    bit           mv;
    bit           dn;
    int           sc;
  } mdl_t;
  mdl_t m [2];

  always #5 clk = ~clk;

  mult_operand_sequencer #(.DW(DW), .NCH(NCH), .CW(CW), .RUN_LEN(4), .SCW(SCW)) u_len4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .std_i(std_i),
    .adc_effective(adc_effective), .adc_valid(adc_valid),
    .count_global(count_global[0]), .mult_2(mult_2[0]), .mult_valid(mult_valid[0]),
    .busy(busy[0]), .done(done[0]), .state_o(state_o[0])
  );

  mult_operand_sequencer #(.DW(DW), .NCH(NCH), .CW(CW), .RUN_LEN(0), .SCW(SCW)) u_len0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .std_i(std_i),
    .adc_effective(adc_effective), .adc_valid(adc_valid),
    .count_global(count_global[1]), .mult_2(mult_2[1]), .mult_valid(mult_valid[1]),
    .busy(busy[1]), .done(done[1]), .state_o(state_o[1])
  );

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].st = 0; m[i].cg = 0; m[i].m2 = '0; m[i].mv = 0; m[i].dn = 0; m[i].sc = 0;
    end
  endfunction

  // Phase rules: load std at 1 and 7, clear at 20, run from 23; states IDLE/CAL/RUN/DONE = 0..3
  function automatic void model_step(int i);
    mdl_t n;
    n = m[i];
    n.mv = 0;
    n.dn = 0;
    if (stop) begin
      n.st = 0; n.cg = 0;
    end else if (m[i].st == 0) begin
      if (start) begin n.st = 1; n.cg = 1; n.sc = 0; end
    end else if (m[i].st == 1) begin
      if (m[i].cg == 1 || m[i].cg == 7) begin n.m2 = std_i; n.mv = 1; end
      if (m[i].cg == 20) begin n.m2 = '0; n.mv = 1; end
      if (m[i].cg < 23) n.cg = m[i].cg + 1;
      else n.st = 2;
    end else if (m[i].st == 2) begin
      if (adc_valid) begin
        n.m2 = adc_effective;
        n.mv = 1;
        n.sc = (m[i].sc + 1) % (2 ** SCW);
        if (run_len[i] != 0 && m[i].sc + 1 == run_len[i]) begin n.st = 3; n.dn = 1; end
      end
    end else begin
      n.st = 0; n.cg = 0;
    end
    m[i] = n;
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, ncyc, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.count_global[%0d]", tag, i), W'(count_global[i]), W'(m[i].cg));
      chk($sformatf("%s.mult_2[%0d]", tag, i), mult_2[i], m[i].m2);
      chk($sformatf("%s.mult_valid[%0d]", tag, i), W'(mult_valid[i]), W'(m[i].mv));
      chk($sformatf("%s.busy[%0d]", tag, i), W'(busy[i]), W'(m[i].st == 1 || m[i].st == 2));
      chk($sformatf("%s.done[%0d]", tag, i), W'(done[i]), W'(m[i].dn));
      chk($sformatf("%s.state[%0d]", tag, i), W'(state_o[i]), W'(m[i].st));
    end
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    ncyc++;
    if (rst) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run_to_run_phase(string tag);
    for (int k = 0; k < 40 && m[0].st != 2; k++) cycle(tag);
    chk({tag, ".reach_run"}, W'(state_o[0]), W'(2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Calibration with fixed standard values, then four sparse samples
    std_i = 64'hAAAA0001_55550001;
    start = 1'b1;
    cycle("cal_start");
    start = 1'b0;
    chk("cal_first_phase", W'(count_global[0]), W'(1));
    run_to_run_phase("cal");
    chk("cal_end_count", W'(count_global[0]), W'(23));
    chk("cal_cleared", mult_2[0], '0);
    for (int k = 0; k < 4; k++) begin
      adc_valid = 1'b1;
      adc_effective = {$urandom(), 32'(32'h10 * (k + 1))};
      cycle("run_sample");
      chk("run_sample_low", W'(mult_2[0][31:0]), W'(32'h10 * (k + 1)));
      adc_valid = 1'b0;
      adc_effective = {$urandom(), $urandom()};
      if (k < 3) cycle("run_gap");
    end
    chk("done_pulse", W'(done[0]), W'(1));
    cycle("after_done");
    chk("done_to_idle", W'(state_o[0]), W'(0));
    chk("done_count_zero", W'(count_global[0]), W'(0));
    chk("len0_still_run", W'(state_o[1]), W'(2));
    stop = 1'b1;
    cycle("stop_len0");
    stop = 1'b0;

    // Stop at phase 8 with start and adc_valid also high
    std_i = {$urandom(), $urandom()};
    start = 1'b1;
    cycle("stop8_start");
    start = 1'b0;
    for (int k = 0; k < 20 && m[0].cg != 8; k++) cycle("stop8_cal");
    stop = 1'b1; start = 1'b1; adc_valid = 1'b1;
    cycle("stop8_edge");
    stop = 1'b0; start = 1'b0; adc_valid = 1'b0;
    chk("stop8_idle", W'(state_o[0]), W'(0));
    chk("stop8_retains_std", mult_2[0], std_i);
    chk("stop8_no_done", W'(done[0]), W'(0));

    // Start held high throughout: restart only after IDLE
    start = 1'b1;
    for (int k = 0; k < 70; k++) begin
      adc_valid = 1'($urandom_range(0, 1));
      adc_effective = {$urandom(), $urandom()};
      if (k == 30) std_i = {$urandom(), $urandom()};
      cycle("start_held");
    end
    start = 1'b0; adc_valid = 1'b0;
    stop = 1'b1;
    cycle("start_held_stop");
    stop = 1'b0;

    // Asynchronous reset mid-RUN
    start = 1'b1;
    cycle("rst_start");
    start = 1'b0;
    run_to_run_phase("rst_cal");
    adc_valid = 1'b1;
    adc_effective = {$urandom(), $urandom()};
    cycle("rst_sample");
    adc_valid = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    chk("async_rst_mult", mult_2[0], '0);
    #1 rst = 1'b0;
    start = 1'b1;
    cycle("restart");
    start = 1'b0;
    chk("restart_phase1", W'(count_global[0]), W'(1));
    run_to_run_phase("restart_cal");

    // RUN_LEN=0 instance accepts 40 samples without completing
    for (int k = 0; k < 40; k++) begin
      adc_valid = 1'b1;
      adc_effective = {$urandom(), $urandom()};
      cycle("len0_samples");
    end
    adc_valid = 1'b0;
    chk("len0_stays_run", W'(state_o[1]), W'(2));
    chk("len0_last_sample", mult_2[1], adc_effective);
    stop = 1'b1;
    cycle("len0_stop");
    stop = 1'b0;
    chk("len0_stop_idle", W'(state_o[1]), W'(0));
    cycle("tail");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
